cell_mem_arbiter: RTL and testbench

- Arbitrates the single-port cell-state memory between three requesters:
  - the pattern loader (writes only),
  - the generation engine (read/write; may lock for atomic read-then-write pairs),
  - the display scanner (reads only).
- Sits between the main game FSM's datapath strobes and the cell RAM.
- Issues one registered memory command per cycle and returns read data with a per-requester valid strobe.

---
 rtl/cell_arb_pkg.sv | 19 +
 rtl/cell_arb_pipe.sv | 74 +++++++
 rtl/cell_mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_cell_mem_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cell_arb_pkg.sv
// Shared constants for the cell-memory arbiter.
//   - requester tags (LOADER/ENGINE/DISPLAY) carried down the command pipe
//   - arbiter state encoding (FREE/LOCKED)
//   - default address/data widths for a 512 x 1 cell RAM
package cell_arb_pkg;

   localparam int unsigned DEF_ADDR_W = 9;
   localparam int unsigned DEF_DATA_W = 1;

   typedef logic [1:0] req_tag_t;

   localparam req_tag_t LOADER  = 2'd0;
   localparam req_tag_t ENGINE  = 2'd1;
   localparam req_tag_t DISPLAY = 2'd2;

   localparam logic [0:0] FREE   = 1'b0;
   localparam logic [0:0] LOCKED = 1'b1;

endpackage

// File: rtl/cell_arb_pipe.sv
// Two-stage command/readback pipeline for the cell RAM.
//   Stage 1 registers the granted command (mem_en/we/addr/wdata) plus the requester tag.
//   Stage 2 raises the per-requester read-valid strobe one cycle after a read command,
//   which is when the RAM's registered output mem_rdata_i carries the data.
// Ports:
//   clka, reset             clock, synchronous active-high reset (drops everything in flight)
//   cmd_*_i                 granted command from the arbiter (cmd_valid_i = any grant)
//   mem_*_o                 registered RAM command
//   mem_rdata_i             RAM read data, one cycle after mem_en_o
//   eg_rvalid_o/dp_rvalid_o read-valid strobes, rd_data_o read data (zero when not valid)
module cell_arb_pipe
   import cell_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              clka,
   input  logic              reset,
   input  logic              cmd_valid_i,
   input  logic              cmd_we_i,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [DATA_W-1:0] cmd_wdata_i,
   input  req_tag_t          cmd_tag_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic              eg_rvalid_o,
   output logic              dp_rvalid_o,
   output logic [DATA_W-1:0] rd_data_o
);

   logic              en_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   req_tag_t          tag_q;
   logic              eg_rv_q;
   logic              dp_rv_q;

   always_ff @(posedge clka) begin
      if (reset) begin
         en_q    <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         tag_q   <= LOADER;
         eg_rv_q <= 1'b0;
         dp_rv_q <= 1'b0;
      end else begin
         en_q <= cmd_valid_i;
         // Address/data hold their last value between commands.
         if (cmd_valid_i) begin
            we_q    <= cmd_we_i;
            addr_q  <= cmd_addr_i;
            wdata_q <= cmd_wdata_i;
            tag_q   <= cmd_tag_i;
         end
         eg_rv_q <= en_q & ~we_q & (tag_q == ENGINE);
         dp_rv_q <= en_q & ~we_q & (tag_q == DISPLAY);
      end
   end

   assign mem_en_o    = en_q;
   assign mem_we_o    = en_q & we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign eg_rvalid_o = eg_rv_q;
   assign dp_rvalid_o = dp_rv_q;
   // The RAM output is already registered; gate it so rd_data is zero outside a valid strobe.
   assign rd_data_o   = (eg_rv_q | dp_rv_q) ? mem_rdata_i : '0;

endmodule

// File: rtl/cell_mem_arbiter.sv
// Arbiter for the single-port cell-state RAM shared by the pattern loader (write only),
// the generation engine (read/write, may lock for atomic read-modify-write) and the
// display scanner (read only).
// Ports:
//   clka, reset, hold          clock, sync active-high reset, grant freeze
//   ld_* / eg_* / dp_*         requester interfaces; *_gnt are combinational
//   eg_rvalid, dp_rvalid       read-valid strobes, rd_data read data
//   mem_*                      registered RAM command, mem_rdata 1-cycle-latency read data
//   lock_err                   sticky lock-timeout flag
//   idle                       FREE, nothing granted, nothing in flight
module cell_mem_arbiter
   import cell_arb_pkg::*;
#(
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned LOCK_MAX = 4
) (
   input  logic              clka,
   input  logic              reset,
   input  logic              hold,
   input  logic              ld_req,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   output logic              ld_gnt,
   input  logic              eg_req,
   input  logic              eg_we,
   input  logic              eg_lock,
   input  logic [ADDR_W-1:0] eg_addr,
   input  logic [DATA_W-1:0] eg_wdata,
   output logic              eg_gnt,
   output logic              eg_rvalid,
   input  logic              dp_req,
   input  logic [ADDR_W-1:0] dp_addr,
   output logic              dp_gnt,
   output logic              dp_rvalid,
   output logic [DATA_W-1:0] rd_data,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              lock_err,
   output logic              idle
);

   localparam int unsigned CntW = $clog2(LOCK_MAX + 1);

   logic [0:0]    state_q, state_d;
   req_tag_t      rr_last_q, rr_last_d;
   logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
   logic          lock_err_q, lock_err_d;

   logic              cmd_valid;
   logic              cmd_we;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   req_tag_t          cmd_tag;

   // Grant selection.
   always_comb begin
      ld_gnt = 1'b0;
      eg_gnt = 1'b0;
      dp_gnt = 1'b0;
      if (!reset && !hold) begin
         if (state_q == FREE) begin
            if (ld_req) begin
               ld_gnt = 1'b1;
            end else if (eg_req && dp_req) begin
               // Round-robin between engine and display only.
               if (rr_last_q == ENGINE) dp_gnt = 1'b1;
               else                     eg_gnt = 1'b1;
            end else if (eg_req) begin
               eg_gnt = 1'b1;
            end else if (dp_req) begin
               dp_gnt = 1'b1;
            end
         end else begin
            eg_gnt = eg_req;
         end
      end
   end

   // Lock FSM, lock counter and round-robin history.
   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      lock_err_d = lock_err_q;
      rr_last_d  = rr_last_q;
      if (eg_gnt)      rr_last_d = ENGINE;
      else if (dp_gnt) rr_last_d = DISPLAY;
      if (state_q == FREE) begin
         lock_cnt_d = '0;
         if (eg_gnt && eg_lock) state_d = LOCKED;
      end else begin
         lock_cnt_d = lock_cnt_q + CntW'(1);
         if (lock_cnt_q == CntW'(LOCK_MAX - 1)) begin
            // Timeout wins over everything, including hold.
            state_d    = FREE;
            lock_cnt_d = '0;
            lock_err_d = 1'b1;
         end else if (eg_gnt) begin
            if (!eg_lock) begin
               state_d    = FREE;
               lock_cnt_d = '0;
            end
         end else if (!hold) begin
            // Engine dropped its request: release the lock.
            state_d    = FREE;
            lock_cnt_d = '0;
         end
      end
   end

   always_ff @(posedge clka) begin
      if (reset) begin
         state_q    <= FREE;
         rr_last_q  <= DISPLAY;
         lock_cnt_q <= '0;
         lock_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_last_q  <= rr_last_d;
         lock_cnt_q <= lock_cnt_d;
         lock_err_q <= lock_err_d;
      end
   end

   // Command mux for the granted requester.
   always_comb begin
      cmd_valid = ld_gnt | eg_gnt | dp_gnt;
      cmd_we    = ld_gnt | (eg_gnt & eg_we);
      cmd_addr  = dp_addr;
      cmd_wdata = '0;
      cmd_tag   = DISPLAY;
      if (ld_gnt) begin
         cmd_addr  = ld_addr;
         cmd_wdata = ld_wdata;
         cmd_tag   = LOADER;
      end else if (eg_gnt) begin
         cmd_addr  = eg_addr;
         cmd_wdata = eg_wdata;
         cmd_tag   = ENGINE;
      end
   end

   cell_arb_pipe #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_pipe (
      .clka        (clka),
      .reset       (reset),
      .cmd_valid_i (cmd_valid),
      .cmd_we_i    (cmd_we),
      .cmd_addr_i  (cmd_addr),
      .cmd_wdata_i (cmd_wdata),
      .cmd_tag_i   (cmd_tag),
      .mem_rdata_i (mem_rdata),
      .mem_en_o    (mem_en),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .eg_rvalid_o (eg_rvalid),
      .dp_rvalid_o (dp_rvalid),
      .rd_data_o   (rd_data)
   );

   assign lock_err = lock_err_q;
   assign idle     = (state_q == FREE) & ~(ld_gnt | eg_gnt | dp_gnt) & ~mem_en
                     & ~eg_rvalid & ~dp_rvalid;

endmodule

// File: tb/tb_cell_mem_arbiter.sv
// Bench for cell_mem_arbiter: per-cycle vectors of inputs and expected grants, a
// synchronous RAM model, and a read scoreboard filled at grant time.
module tb_cell_mem_arbiter;
   import cell_arb_pkg::*;

   localparam int unsigned AW = 9;
   localparam int unsigned DW = 1;

   logic clka = 1'b0;
   always #5 clka = ~clka;

   logic          reset, hold;
   logic          ld_req, eg_req, eg_we, eg_lock, dp_req;
   logic [AW-1:0] ld_addr, eg_addr, dp_addr;
   logic [DW-1:0] ld_wdata, eg_wdata;
   logic          ld_gnt, eg_gnt, dp_gnt, eg_rvalid, dp_rvalid;
   logic [DW-1:0] rd_data, mem_wdata, mem_rdata;
   logic          mem_en, mem_we, lock_err, idle;
   logic [AW-1:0] mem_addr;

   cell_mem_arbiter #(
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .LOCK_MAX (4)
   ) dut (
      .clka      (clka),
      .reset     (reset),
      .hold      (hold),
      .ld_req    (ld_req),
      .ld_addr   (ld_addr),
      .ld_wdata  (ld_wdata),
      .ld_gnt    (ld_gnt),
      .eg_req    (eg_req),
      .eg_we     (eg_we),
      .eg_lock   (eg_lock),
      .eg_addr   (eg_addr),
      .eg_wdata  (eg_wdata),
      .eg_gnt    (eg_gnt),
      .eg_rvalid (eg_rvalid),
      .dp_req    (dp_req),
      .dp_addr   (dp_addr),
      .dp_gnt    (dp_gnt),
      .dp_rvalid (dp_rvalid),
      .rd_data   (rd_data),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .lock_err  (lock_err),
      .idle      (idle)
   );

   // Synchronous single-port RAM, one-cycle read latency.
   logic mem [512];
   logic ref_mem [512];
   always @(posedge clka) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] = mem_wdata[0];
         else        mem_rdata[0]  = mem[mem_addr];
      end
   end

   typedef struct {
      string         nm;
      logic          rst, hld, ld, eg, we, lk, dp;
      logic [AW-1:0] la, ea, da;
      logic          lw, ew;
      logic [2:0]    g;      // {ld, eg, dp}
      logic          lerr;
      logic          idl;    // x = not checked
      logic          chkr;   // also check reset values of datapath outputs
   } vec_t;

   typedef struct {
      int   due;
      logic is_eg;
      logic d;
   } rd_t;

   rd_t  sb[$];
   vec_t tbl[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   logic          exp_en = 1'b0;
   logic          exp_we = 1'b0;
   logic [AW-1:0] exp_addr = '0;
   logic          exp_wd = 1'b0;

   function automatic vec_t mk(input string nm, input logic rst, input logic hld,
                               input logic ld, input logic eg, input logic we, input logic lk,
                               input logic dp, input int la, input int ea, input int da,
                               input logic lw, input logic ew, input logic [2:0] g,
                               input logic lerr, input logic idl, input logic chkr);
      vec_t v;
      v.nm = nm; v.rst = rst; v.hld = hld; v.ld = ld; v.eg = eg; v.we = we; v.lk = lk;
      v.dp = dp; v.la = AW'(la); v.ea = AW'(ea); v.da = AW'(da); v.lw = lw; v.ew = ew;
      v.g = g; v.lerr = lerr; v.idl = idl; v.chkr = chkr;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic step(input vec_t v);
      reset = v.rst; hold = v.hld;
      ld_req = v.ld; ld_addr = v.la; ld_wdata = v.lw;
      eg_req = v.eg; eg_we = v.we; eg_lock = v.lk; eg_addr = v.ea; eg_wdata = v.ew;
      dp_req = v.dp; dp_addr = v.da;
      @(negedge clka);
      // Read returns due this cycle.
      if (sb.size() > 0 && sb[0].due == cyc) begin
         chk({v.nm, ":rvalid"}, {30'd0, eg_rvalid, dp_rvalid}, {30'd0, sb[0].is_eg, ~sb[0].is_eg});
         chk({v.nm, ":rd_data"}, 32'(rd_data), 32'(sb[0].d));
         void'(sb.pop_front());
      end else begin
         chk({v.nm, ":no_rvalid"}, {30'd0, eg_rvalid, dp_rvalid}, 32'd0);
      end
      // Command issued for last cycle's grant.
      chk({v.nm, ":mem_en"}, 32'(mem_en), 32'(exp_en));
      if (exp_en) begin
         chk({v.nm, ":mem_we"}, 32'(mem_we), 32'(exp_we));
         chk({v.nm, ":mem_addr"}, 32'(mem_addr), 32'(exp_addr));
         if (exp_we) chk({v.nm, ":mem_wdata"}, 32'(mem_wdata), 32'(exp_wd));
      end
      chk({v.nm, ":gnt"}, {29'd0, ld_gnt, eg_gnt, dp_gnt}, {29'd0, v.g});
      chk({v.nm, ":lock_err"}, 32'(lock_err), 32'(v.lerr));
      if (v.idl !== 1'bx) chk({v.nm, ":idle"}, 32'(idle), 32'(v.idl));
      if (v.chkr) begin
         chk({v.nm, ":rst_addr"}, 32'(mem_addr), 32'd0);
         chk({v.nm, ":rst_wdata"}, 32'(mem_wdata), 32'd0);
         chk({v.nm, ":rst_we"}, 32'(mem_we), 32'd0);
         chk({v.nm, ":rst_rd_data"}, 32'(rd_data), 32'd0);
      end
      // Expectations for what this cycle's grant produces.
      if (v.rst) begin
         sb.delete();
         exp_en = 1'b0;
      end else begin
         exp_en = |v.g;
         if (v.g[2]) begin
            exp_we = 1'b1; exp_addr = v.la; exp_wd = v.lw;
            ref_mem[v.la] = v.lw;
         end else if (v.g[1]) begin
            exp_we = v.we; exp_addr = v.ea; exp_wd = v.ew;
            if (v.we) ref_mem[v.ea] = v.ew;
            else      sb.push_back('{cyc + 2, 1'b1, ref_mem[v.ea]});
         end else if (v.g[0]) begin
            exp_we = 1'b0; exp_addr = v.da;
            sb.push_back('{cyc + 2, 1'b0, ref_mem[v.da]});
         end
      end
      @(posedge clka);
      cyc++;
      #1;
   endtask

   initial begin
      for (int i = 0; i < 512; i++) begin
         mem[i] = i[0];
         ref_mem[i] = i[0];
      end
      mem_rdata = '0;
      reset = 1'b1; hold = 1'b0;
      ld_req = 1'b0; eg_req = 1'b0; dp_req = 1'b0; eg_we = 1'b0; eg_lock = 1'b0;
      ld_addr = '0; eg_addr = '0; dp_addr = '0; ld_wdata = '0; eg_wdata = '0;
      repeat (2) @(posedge clka);
      #1;

      // Reset values, loader priority, engine/display round-robin.
      tbl.push_back(mk("rst",      1,0, 0,0,0,0,0,  0, 0, 0, 0,0, 3'b000, 0, 1,    1));
      tbl.push_back(mk("ld_pri",   0,0, 1,1,0,0,1,  7, 3, 4, 1,0, 3'b100, 0, 0,    0));
      tbl.push_back(mk("ld_cmd",   0,0, 0,0,0,0,0,  0, 0, 0, 0,0, 3'b000, 0, 0,    0));
      tbl.push_back(mk("ld_done",  0,0, 0,0,0,0,0,  0, 0, 0, 0,0, 3'b000, 0, 1,    0));
      for (int k = 0; k < 6; k++)
         tbl.push_back(mk($sformatf("rr%0d", k), 0,0, 0,1,0,0,1, 0, 10 + k, 20 + k, 0,0,
                          (k % 2 == 0) ? 3'b010 : 3'b001, 0, 0, 0));
      tbl.push_back(mk("rr_dr0",   0,0, 0,0,0,0,0,  0, 0, 0, 0,0, 3'b000, 0, 0,    0));
      tbl.push_back(mk("rr_dr1",   0,0, 0,0,0,0,0,  0, 0, 0, 0,0, 3'b000, 0, 0,    0));
      tbl.push_back(mk("rr_dr2",   0,0, 0,0,0,0,0,  0, 0, 0, 0,0, 3'b000, 0, 1,    0));
      foreach (tbl[i]) step(tbl[i]);

      // Locked read-then-write with the loader waiting.
      step(mk("lk_rd",    0,0, 0,1,0,1,0,  0, 5, 0, 0,0, 3'b010, 0, 0,    0));
      step(mk("lk_wr",    0,0, 1,1,1,0,0,  9, 5, 0, 1,0, 3'b010, 0, 0,    0));
      step(mk("lk_ld",    0,0, 1,0,0,0,0,  9, 0, 0, 1,0, 3'b100, 0, 0,    0));
      step(mk("lk_dr0",   0,0, 0,0,0,0,0,  0, 0, 0, 0,0, 3'b000, 0, 0,    0));
      step(mk("lk_dr1",   0,0, 0,0,0,0,0,  0, 0, 0, 0,0, 3'b000, 0, 1,    0));

      // Lock timeout: 4 LOCKED cycles, then forced release and display wins.
      step(mk("to_enter", 0,0, 0,1,0,1,0,  0, 30, 0, 0,0, 3'b010, 0, 0,   0));
      for (int k = 1; k <= 4; k++)
         step(mk($sformatf("to_lk%0d", k), 0,0, 0,1,0,1,1, 0, 30 + k, 40, 0,0, 3'b010, 0, 0, 0));
      step(mk("to_dp",    0,0, 0,1,0,1,1,  0, 35, 41, 0,0, 3'b001, 1, 0,  0));
      step(mk("to_eg",    0,0, 0,1,0,0,0,  0, 36, 0, 0,0, 3'b010, 1, 0,   0));
      step(mk("to_dr0",   0,0, 0,0,0,0,0,  0, 0, 0, 0,0, 3'b000, 1, 1'bx, 0));
      step(mk("to_dr1",   0,0, 0,0,0,0,0,  0, 0, 0, 0,0, 3'b000, 1, 1'bx, 0));

      // Hold while LOCKED: no grants, in-flight read still returns, lock kept.
      step(mk("hd_enter", 0,0, 0,1,0,1,0,  0, 43, 0, 0,0, 3'b010, 1, 0,   0));
      step(mk("hd_h0",    0,1, 1,1,0,1,1,  43, 43, 44, 0,0, 3'b000, 1, 0, 0));
      step(mk("hd_h1",    0,1, 1,1,0,1,1,  43, 43, 44, 0,0, 3'b000, 1, 0, 0));
      step(mk("hd_wr",    0,0, 1,1,1,0,1,  43, 43, 44, 0,0, 3'b010, 1, 0, 0));
      step(mk("hd_ld",    0,0, 1,0,0,0,1,  45, 0, 44, 0,0, 3'b100, 1, 0,  0));
      step(mk("hd_dp",    0,0, 0,0,0,0,1,  0, 0, 44, 0,0, 3'b001, 1, 0,   0));
      step(mk("hd_dr0",   0,0, 0,0,0,0,0,  0, 0, 0, 0,0, 3'b000, 1, 0,    0));
      step(mk("hd_dr1",   0,0, 0,0,0,0,0,  0, 0, 0, 0,0, 3'b000, 1, 0,    0));

      // Reset one cycle after an engine read grant drops the read.
      step(mk("rs_rd",    0,0, 0,1,0,0,0,  0, 51, 0, 0,0, 3'b010, 1, 0,   0));
      step(mk("rs_rst",   1,0, 0,1,0,0,0,  0, 51, 0, 0,0, 3'b000, 1, 1'bx, 0));
      step(mk("rs_after", 0,0, 0,0,0,0,0,  0, 0, 0, 0,0, 3'b000, 0, 1,    1));
      step(mk("rs_quiet", 0,0, 0,0,0,0,0,  0, 0, 0, 0,0, 3'b000, 0, 1,    0));

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
